// File: rtl/adc_avg_accum.sv
// rtl/adc_avg_accum.sv - triggered multi-channel ADC capture with coherent averaging to AXI-Stream
module adc_avg_accum #(
    parameter int NUM_CH    = 2,
    parameter int SPB       = 8,
    parameter int SAMPLE_W  = 16,
    parameter int DEPTH     = 256,
    parameter int MAX_SHIFT = 8,
    parameter int CFG_W     = 16
) (
    input  logic                           pl_clk,
    input  logic                           rst,
    input  logic [CFG_W-1:0]               cfg_run_cycles,
    input  logic [3:0]                     cfg_shift,
    input  logic                           arm,
    input  logic                           abort,
    input  logic                           trigger,
    input  logic [NUM_CH*SPB*SAMPLE_W-1:0] s_axis_tdata,
    input  logic                           s_axis_tvalid,
    output logic                           s_axis_tready,
    output logic [2*SAMPLE_W-1:0]          m_axis_tdata,
    output logic                           m_axis_tvalid,
    output logic                           m_axis_tlast,
    input  logic                           m_axis_tready,
    output logic                           busy,
    output logic                           done,
    output logic                           err
);
    localparam int ACC_W = SAMPLE_W + MAX_SHIFT;
    localparam int LANES = NUM_CH * SPB;
    localparam int WPR   = LANES / 2;
    localparam int AW    = $clog2(DEPTH);
    localparam int RW    = AW + 1;
    localparam int PW    = MAX_SHIFT + 1;
    localparam int WW    = (WPR > 1) ? $clog2(WPR) : 1;
    localparam int ROW_W = LANES * ACC_W;
    localparam int SMP_W = LANES * SAMPLE_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_CAPTURE,
        S_WAIT_TRIG,
        S_READOUT
    } state_t;

    state_t state, state_d;

    logic [RW-1:0]           run, run_clamp;
    logic [3:0]              sh, sh_clamp;
    logic [PW-1:0]           pass_cnt;
    logic [AW-1:0]           beat_cnt;
    logic                    accept, beat_last, last_pass;

    logic                    wr_valid, wr_first;
    logic [AW-1:0]           wr_addr;
    logic [SMP_W-1:0]        wr_sample;
    logic [ROW_W-1:0]        wr_data, ram_q;
    logic [ROW_W-1:0]        mem [DEPTH];
    logic                    rd_en;
    logic [AW-1:0]           rd_addr;

    logic [RW-1:0]           fetch_row;
    logic                    pf_full, out_valid, s_tready_r;
    logic [AW-1:0]           out_row;
    logic [WW-1:0]           word_idx;
    logic [SMP_W-1:0]        row_buf, avg_row;
    logic                    ro, hs, row_end, load, issue;
    logic signed [ACC_W-1:0] lane_acc, lane_smp;

    always_comb begin
        if (cfg_run_cycles == '0)
            run_clamp = RW'(1);
        else if (cfg_run_cycles > CFG_W'(DEPTH))
            run_clamp = RW'(DEPTH);
        else
            run_clamp = RW'(cfg_run_cycles);
        sh_clamp = (cfg_shift > 4'(MAX_SHIFT)) ? 4'(MAX_SHIFT) : cfg_shift;
    end

    assign accept    = (state == S_CAPTURE) && s_axis_tvalid;
    assign beat_last = (beat_cnt == AW'(run - RW'(1)));
    assign last_pass = (pass_cnt == ((PW'(1) << sh) - PW'(1)));

    // Readout prefetches the next RAM row while the current one drains, so
    // rows stream back-to-back; the final accumulate write must land first.
    assign ro      = (state == S_READOUT);
    assign hs      = out_valid && m_axis_tready;
    assign row_end = hs && (word_idx == WW'(WPR - 1));
    assign load    = ro && pf_full && (!out_valid || row_end);
    assign issue   = ro && !wr_valid && (fetch_row != run) && (!pf_full || load);
    assign rd_en   = accept || issue;
    assign rd_addr = accept ? beat_cnt : fetch_row[AW-1:0];

    always_ff @(posedge pl_clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_d;
    end

    always_comb begin
        state_d = state;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state)
                S_IDLE:      if (arm) state_d = S_ARMED;
                S_ARMED,
                S_WAIT_TRIG: if (trigger) state_d = S_CAPTURE;
                S_CAPTURE:   if (accept && beat_last) state_d = last_pass ? S_READOUT : S_WAIT_TRIG;
                S_READOUT:   if (hs && m_axis_tlast) state_d = S_IDLE;
                default:     state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge pl_clk or posedge rst) begin
        if (rst) begin
            run <= RW'(1);
            sh  <= '0;
        end else if (state == S_IDLE && arm) begin
            run <= run_clamp;
            sh  <= sh_clamp;
        end
    end

    always_comb begin
        wr_data  = '0;
        lane_smp = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_smp = ACC_W'($signed(wr_sample[l*SAMPLE_W +: SAMPLE_W]));
            wr_data[l*ACC_W +: ACC_W] = wr_first ? lane_smp : lane_smp + ram_q[l*ACC_W +: ACC_W];
        end
    end

    always_comb begin
        avg_row  = '0;
        lane_acc = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_acc = ram_q[l*ACC_W +: ACC_W];
            avg_row[l*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'(lane_acc >>> sh);
        end
    end

    // Pass 0 overwrites, so the RAM never needs clearing between runs.
    always_ff @(posedge pl_clk) begin
        if (wr_valid)
            mem[wr_addr] <= wr_data;
        if (rd_en)
            ram_q <= mem[rd_addr];
    end

    always_ff @(posedge pl_clk or posedge rst) begin
        if (rst) begin
            s_tready_r <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            pass_cnt   <= '0;
            beat_cnt   <= '0;
            wr_valid   <= 1'b0;
            wr_first   <= 1'b0;
            wr_addr    <= '0;
            wr_sample  <= '0;
            fetch_row  <= '0;
            pf_full    <= 1'b0;
            out_valid  <= 1'b0;
            out_row    <= '0;
            word_idx   <= '0;
            row_buf    <= '0;
        end else begin
            s_tready_r <= 1'b1;
            done       <= 1'b0;
            wr_valid   <= accept;
            if (accept) begin
                wr_addr   <= beat_cnt;
                wr_first  <= (pass_cnt == '0);
                wr_sample <= s_axis_tdata;
                if (beat_last) begin
                    beat_cnt <= '0;
                    pass_cnt <= pass_cnt + PW'(1);
                end else begin
                    beat_cnt <= beat_cnt + AW'(1);
                end
            end
            if (state == S_CAPTURE && trigger)
                err <= 1'b1;

            if (issue)
                fetch_row <= fetch_row + RW'(1);
            if (issue)
                pf_full <= 1'b1;
            else if (load)
                pf_full <= 1'b0;

            if (load) begin
                row_buf   <= avg_row;
                out_valid <= 1'b1;
                word_idx  <= '0;
            end else if (row_end) begin
                out_valid <= 1'b0;
            end else if (hs) begin
                word_idx <= word_idx + WW'(1);
            end
            if (row_end)
                out_row <= out_row + AW'(1);
            if (hs && m_axis_tlast)
                done <= 1'b1;

            if (state == S_IDLE && arm) begin
                err       <= 1'b0;
                pass_cnt  <= '0;
                beat_cnt  <= '0;
                fetch_row <= '0;
                out_row   <= '0;
            end
            if (abort) begin
                beat_cnt  <= '0;
                wr_valid  <= 1'b0;
                pf_full   <= 1'b0;
                out_valid <= 1'b0;
                done      <= 1'b0;
            end
        end
    end

    always_comb begin
        m_axis_tdata = '0;
        for (int w = 0; w < WPR; w++)
            if (word_idx == WW'(w))
                m_axis_tdata = row_buf[w*2*SAMPLE_W +: 2*SAMPLE_W];
    end

    assign m_axis_tvalid = out_valid;
    assign m_axis_tlast  = out_valid && (word_idx == WW'(WPR - 1)) && (out_row == AW'(run - RW'(1)));
    assign s_axis_tready = s_tready_r;
    assign busy          = (state != S_IDLE);

endmodule
